alu_op_issuer: RTL and testbench

//  Initiator side of the ALU interface: accepts one ALU command (opcode + A/B/C operands)

---
 rtl/alu_op_issuer.sv | 142 ++++++++++++++
 tb/tb_alu_op_issuer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_op_issuer                                              |
// | Description : Initiator side of the ALU interface. Accepts one command   |
// |               (opcode + A/B/C) over valid/ready, presents it to the      |
// |               combinational ALU, waits a fixed settle time, then returns |
// |               the ALU result and P flag on a valid/ready response        |
// |               channel. The ALU is parked on CLEAR (4'b0000) when idle.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clock, reset          rising-edge clock, synchronous active-high reset |
// |   cmd_valid/cmd_ready   command handshake                                |
// |   cmd_op/a/b/c          opcode and operands                              |
// |   alu_a/b/c, alu_ctrl   registered operands / opcode driven to the ALU   |
// |   alu_out, alu_p        ALU result and P flag                            |
// |   rsp_valid/rsp_ready   response handshake                               |
// |   rsp_data/p/err        captured result, P flag, illegal-opcode flag     |
// |   busy                  high whenever not IDLE                           |
// |   op_count              completed legal operations (wrapping)            |
// +--------------------------------------------------------------------------+
module alu_op_issuer #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 1,   // legal range 1..15
  parameter int MAX_OP        = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [WIDTH-1:0] cmd_c,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_c,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_p,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_p,
  output logic             rsp_err,
  output logic             busy,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_OP_CLEAR    = 4'b0000;
  localparam logic [3:0] c_MAX_OP      = 4'(MAX_OP);
  // The operands are registered at the accept edge; the counter then runs
  // SETTLE_CYCLES-1 .. 0 so the ALU output is captured after exactly
  // SETTLE_CYCLES full cycles of stable inputs.
  localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_settle;

  // Ready depends on state only, so the upstream never sees a loop through
  // cmd_valid.
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_settle  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_c     <= '0;
      alu_ctrl  <= c_OP_CLEAR;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_p     <= 1'b0;
      rsp_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_op <= c_MAX_OP) begin
              alu_a    <= cmd_a;
              alu_b    <= cmd_b;
              alu_c    <= cmd_c;
              alu_ctrl <= cmd_op;
              r_settle <= c_SETTLE_LOAD;
              r_state  <= S_WAIT;
            end else begin
              // Illegal opcode: the ALU is never touched, answer at once.
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_p     <= 1'b0;
              rsp_valid <= 1'b1;
              r_state   <= S_RESP;
            end
          end
        end

        S_WAIT: begin
          if (r_settle == 4'd0) begin
            rsp_data  <= alu_out;
            rsp_p     <= alu_p;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end

        S_RESP: begin
          // rsp_valid is always set in this state, so rsp_ready alone
          // completes the handshake. Response fields keep their values.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_c     <= '0;
            alu_ctrl  <= c_OP_CLEAR;
            if (!rsp_err) begin
              op_count <= op_count + 16'd1;
            end
            r_state   <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_alu_op_issuer                                           |
// | Description : Self-checking bench for alu_op_issuer. Two instances run   |
// |               in lock-step (SETTLE_CYCLES = 1 and 3) against an adder    |
// |               ALU stub; a per-instance monitor scores responses against  |
// |               an expected-result queue.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_alu_op_issuer;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] d;    // expected rsp_data
    logic        p;    // expected rsp_p
    logic        err;  // expected rsp_err
  } vec_t;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [15:0] cmd_c;
  logic        rsp_ready;

  logic        cmd_ready [2];
  logic [15:0] alu_a     [2];
  logic [15:0] alu_b     [2];
  logic [15:0] alu_c     [2];
  logic [3:0]  alu_ctrl  [2];
  logic [15:0] alu_out   [2];
  logic        alu_p     [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_data  [2];
  logic        rsp_p     [2];
  logic        rsp_err   [2];
  logic        busy      [2];
  logic [15:0] op_count  [2];

  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   model_cnt = 0;
  vec_t q0[$];
  vec_t q1[$];
  vec_t vecs[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(logic [3:0] op, logic [15:0] a, logic [15:0] b,
                              logic [15:0] c, logic [15:0] d, logic p, logic err);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.c = c; v.d = d; v.p = p; v.err = err;
    return v;
  endfunction

  function automatic int q_size(int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  function automatic vec_t pop_exp(int g);
    vec_t r;
    if (g == 0) r = q0.pop_front();
    else        r = q1.pop_front();
    return r;
  endfunction

  genvar G;
  generate
    for (G = 0; G < 2; G++) begin : g_dut
      localparam int S = (G == 0) ? 1 : 3;

      alu_op_issuer #(.WIDTH(16), .SETTLE_CYCLES(S), .MAX_OP(9)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready[G]),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_c     (cmd_c),
        .alu_a     (alu_a[G]),
        .alu_b     (alu_b[G]),
        .alu_c     (alu_c[G]),
        .alu_ctrl  (alu_ctrl[G]),
        .alu_out   (alu_out[G]),
        .alu_p     (alu_p[G]),
        .rsp_valid (rsp_valid[G]),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data[G]),
        .rsp_p     (rsp_p[G]),
        .rsp_err   (rsp_err[G]),
        .busy      (busy[G]),
        .op_count  (op_count[G])
      );

      assign alu_out[G] = alu_a[G] + alu_b[G] + alu_c[G];
      assign alu_p[G]   = alu_out[G][0];

      int   acc_cyc = 0;
      bit   seen    = 1'b0;
      vec_t cur;

      // Sampled on the falling edge: acc_cyc / the latency refer to the
      // rising edge that follows the sample.
      always @(negedge clock) begin
        if (reset) begin
          seen = 1'b0;
        end else begin
          chk($sformatf("d%0d_ready_vs_busy", G), 32'(cmd_ready[G]), 32'(!busy[G]));
          if (cmd_valid && cmd_ready[G]) acc_cyc = cyc + 1;
          if (rsp_valid[G]) begin
            if (!seen) begin
              if (q_size(G) == 0) begin
                chk($sformatf("d%0d_unexpected_rsp", G), 32'(rsp_valid[G]), 32'd0);
              end else begin
                cur  = pop_exp(G);
                seen = 1'b1;
                chk($sformatf("d%0d_latency_edges", G), 32'(cyc + 1 - acc_cyc),
                    cur.err ? 32'd1 : 32'(S + 1));
              end
            end
            if (seen) begin
              chk($sformatf("d%0d_rsp_data op=%0h", G, cur.op), 32'(rsp_data[G]), 32'(cur.d));
              chk($sformatf("d%0d_rsp_p op=%0h", G, cur.op), 32'(rsp_p[G]), 32'(cur.p));
              chk($sformatf("d%0d_rsp_err op=%0h", G, cur.op), 32'(rsp_err[G]), 32'(cur.err));
            end
            if (rsp_ready) seen = 1'b0;
          end
        end
      end
    end
  endgenerate

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      if (cmd_ready[0] && cmd_ready[1]) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_idle_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic drive(input vec_t v);
    cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; cmd_c = v.c;
    cmd_valid = 1'b1;
    q0.push_back(v);
    q1.push_back(v);
  endtask

  // Called at #1 after a rising edge.
  task automatic issue(input vec_t v);
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready[0] && cmd_ready[1]) break;
      @(posedge clock); #1;
    end
    chk("issue_ready", 32'(cmd_ready[0] & cmd_ready[1]), 32'd1);
    drive(v);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("d%0d_busy_after_accept op=%0h", g, v.op), 32'(busy[g]), 32'd1);
      chk($sformatf("d%0d_alu_ctrl_active op=%0h", g, v.op), 32'(alu_ctrl[g]),
          v.err ? 32'd0 : 32'(v.op));
      chk($sformatf("d%0d_alu_a_active op=%0h", g, v.op), 32'(alu_a[g]),
          v.err ? 32'd0 : 32'(v.a));
    end
    if (!v.err) model_cnt++;
    wait_idle($sformatf("op%0h", v.op));
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("d%0d_alu_ctrl_parked op=%0h", g, v.op), 32'(alu_ctrl[g]), 32'd0);
      chk($sformatf("d%0d_op_count op=%0h", g, v.op), 32'(op_count[g]), 32'(model_cnt));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0;
    cmd_a = '0; cmd_b = '0; cmd_c = '0; rsp_ready = 1'b1;

    // Stimulus table: A+B+C, P = bit 0 of the sum.
    vecs.push_back(mk(4'd1, 16'h0019, 16'h0002, 16'h0005, 16'h0020, 1'b0, 1'b0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(4'(i), 16'd25, 16'd2, 16'd5, 16'h0020, 1'b0, 1'b0));
    vecs.push_back(mk(4'hA, 16'h0019, 16'h0002, 16'h0005, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mk(4'hF, 16'h0019, 16'h0002, 16'h0005, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mk(4'd9, 16'h1234, 16'h1111, 16'h0001, 16'h2346, 1'b0, 1'b0));
    vecs.push_back(mk(4'd7, 16'h8000, 16'h8000, 16'h0001, 16'h0001, 1'b1, 1'b0));

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("d%0d_rst_alu_ctrl", g), 32'(alu_ctrl[g]), 32'd0);
      chk($sformatf("d%0d_rst_rsp_valid", g), 32'(rsp_valid[g]), 32'd0);
      chk($sformatf("d%0d_rst_cmd_ready", g), 32'(cmd_ready[g]), 32'd1);
      chk($sformatf("d%0d_rst_op_count", g), 32'(op_count[g]), 32'd0);
      chk($sformatf("d%0d_rst_busy", g), 32'(busy[g]), 32'd0);
      chk($sformatf("d%0d_rst_rsp_data", g), 32'(rsp_data[g]), 32'd0);
    end
    reset = 1'b0;
    @(posedge clock); #1;

    // Table sweep
    for (int i = 0; i < vecs.size(); i++) issue(vecs[i]);

    // Long backpressure with a second command queued behind the first
    rsp_ready = 1'b0;
    drive(mk(4'd2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0));
    @(posedge clock); #1;
    drive(mk(4'd3, 16'h0100, 16'h0020, 16'h0003, 16'h0123, 1'b1, 1'b0));
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      for (int g = 0; g < 2; g++)
        chk($sformatf("d%0d_bp_cmd_ready cyc%0d", g, i), 32'(cmd_ready[g]), 32'd0);
    end
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("d%0d_bp_rsp_valid", g), 32'(rsp_valid[g]), 32'd1);
      chk($sformatf("d%0d_bp_rsp_data", g), 32'(rsp_data[g]), 32'h0000);
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;          // response handshake edge
    model_cnt++;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("d%0d_bp_idle_after_hs", g), 32'(cmd_ready[g]), 32'd1);
      chk($sformatf("d%0d_bp_count_after_hs", g), 32'(op_count[g]), 32'(model_cnt));
    end
    @(posedge clock); #1;          // queued command taken here
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("d%0d_bp_second_accepted", g), 32'(cmd_ready[g]), 32'd0);
      chk($sformatf("d%0d_bp_second_ctrl", g), 32'(alu_ctrl[g]), 32'd3);
    end
    cmd_valid = 1'b0;
    model_cnt++;
    wait_idle("bp_second");
    for (int g = 0; g < 2; g++)
      chk($sformatf("d%0d_bp_final_count", g), 32'(op_count[g]), 32'(model_cnt));

    // Reset while both instances are in WAIT
    drive(mk(4'd5, 16'h0001, 16'h0002, 16'h0003, 16'h0006, 1'b0, 1'b0));
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("d%0d_mid_rst_alu_ctrl", g), 32'(alu_ctrl[g]), 32'd0);
      chk($sformatf("d%0d_mid_rst_alu_a", g), 32'(alu_a[g]), 32'd0);
      chk($sformatf("d%0d_mid_rst_rsp_valid", g), 32'(rsp_valid[g]), 32'd0);
      chk($sformatf("d%0d_mid_rst_cmd_ready", g), 32'(cmd_ready[g]), 32'd1);
      chk($sformatf("d%0d_mid_rst_busy", g), 32'(busy[g]), 32'd0);
      chk($sformatf("d%0d_mid_rst_op_count", g), 32'(op_count[g]), 32'd0);
      chk($sformatf("d%0d_mid_rst_rsp_err", g), 32'(rsp_err[g]), 32'd0);
    end
    reset = 1'b0;
    q0.delete();
    q1.delete();
    model_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      for (int g = 0; g < 2; g++)
        chk($sformatf("d%0d_no_rsp_after_rst cyc%0d", g, i), 32'(rsp_valid[g]), 32'd0);
    end
    issue(mk(4'd4, 16'h0010, 16'h0020, 16'h0030, 16'h0060, 1'b0, 1'b0));

    repeat (3) @(posedge clock);
    #1;
    chk("d0_scoreboard_drained", 32'(q0.size()), 32'd0);
    chk("d1_scoreboard_drained", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
